// File: rtl/a3_stream_serializer_pkg.sv
// Shared fp32 field positions, FSM state encodings and the subnormal flush helper
// for the level-3 approximation stream serializer.
package a3_stream_serializer_pkg;

    localparam int FP32_W       = 32;
    localparam int FP32_EXP_MSB = 30;
    localparam int FP32_EXP_LSB = 23;
    localparam int FP32_MAN_MSB = 22;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EMIT0 = 2'd1;
    localparam logic [1:0] ST_EMIT1 = 2'd2;

    // Subnormal (exp==0, mantissa!=0) becomes a zero that keeps its sign.
    function automatic logic [FP32_W-1:0] fp32_flush_denorm(input logic [FP32_W-1:0] x);
        logic [FP32_W-1:0] r;
        r = x;
        if ((x[FP32_EXP_MSB:FP32_EXP_LSB] == '0) && (x[FP32_MAN_MSB:0] != '0)) begin
            r = {x[FP32_W-1], {(FP32_W-1){1'b0}}};
        end
        return r;
    endfunction

endpackage

// File: rtl/a3_stream_serializer_pair_sync_fifo.sv
// Single-clock FIFO of (a3_0, a3_1) pairs with a registered occupancy count.
// Writes while full and reads while empty are ignored; clear empties it synchronously.
module pair_sync_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_data,
    input  logic          rd_en,
    output logic [W-1:0]  rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_wr, do_rd;

    assign full    = (count_q == (AW+1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rd_data = mem_q[rd_ptr_q];

    assign do_wr = wr_en & ~full;
    assign do_rd = rd_en & ~empty;

    // Pointers are AW bits wide so they wrap modulo DEPTH on their own.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_wr && !do_rd)      count_d = count_q + 1'b1;
        else if (!do_wr && do_rd) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr && !clear) mem_q[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/a3_stream_serializer.sv
// Buffers fp32 approximation pairs and streams them out a3_0 first over valid/ready.
// Define FP32_DENORM_FLUSH_EN to flush subnormal samples to signed zero on load.
module a3_stream_serializer
    import a3_stream_serializer_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    localparam int AW        = $clog2(FIFO_DEPTH)
) (
    input  logic              clk_312_5,
    input  logic              rst,
    input  logic              clear,
    input  logic              din_valid,
    input  logic [FP32_W-1:0] a3_0,
    input  logic [FP32_W-1:0] a3_1,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [FP32_W-1:0] dout,
    output logic              dout_phase,
    output logic [AW:0]       fifo_level,
    output logic              overflow,
    output logic [1:0]        dbg_state_o
);

    // Output handshake: a sample transfers on a rising edge where dout_valid & dout_ready;
    // while dout_valid is high and dout_ready low, dout, dout_phase and dout_valid hold.

    logic [1:0]        state_q, state_d;
    logic [FP32_W-1:0] dout_q, dout_d;
    logic [FP32_W-1:0] hold_q, hold_d;
    logic              phase_q, phase_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;

    logic [2*FP32_W-1:0] fifo_rd_data;
    logic                fifo_full, fifo_empty, pop;
    logic                accept;

    pair_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (2*FP32_W)
    ) u_fifo (
        .clk     (clk_312_5),
        .rst     (rst),
        .clear   (clear),
        .wr_en   (din_valid),
        .wr_data ({a3_1, a3_0}),
        .rd_en   (pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_level)
    );

    function automatic logic [FP32_W-1:0] load_sample(input logic [FP32_W-1:0] x);
`ifdef FP32_DENORM_FLUSH_EN
        return fp32_flush_denorm(x);
`else
        return x;
`endif
    endfunction

    assign accept = valid_q & dout_ready;

    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        hold_d  = hold_q;
        phase_d = phase_q;
        valid_d = valid_q;
        pop     = 1'b0;
        ovf_d   = ovf_q | (din_valid & fifo_full);
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    dout_d  = load_sample(fifo_rd_data[FP32_W-1:0]);
                    hold_d  = fifo_rd_data[2*FP32_W-1:FP32_W];
                    phase_d = 1'b0;
                    valid_d = 1'b1;
                    state_d = ST_EMIT0;
                end
            end
            ST_EMIT0: begin
                if (accept) begin
                    dout_d  = load_sample(hold_q);
                    phase_d = 1'b1;
                    state_d = ST_EMIT1;
                end
            end
            ST_EMIT1: begin
                // Chain straight into the next pair so the stream has no bubble.
                if (accept) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        dout_d  = load_sample(fifo_rd_data[FP32_W-1:0]);
                        hold_d  = fifo_rd_data[2*FP32_W-1:FP32_W];
                        phase_d = 1'b0;
                        state_d = ST_EMIT0;
                    end else begin
                        valid_d = 1'b0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_312_5 or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            dout_q  <= '0;
            hold_q  <= '0;
            phase_q <= 1'b0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (clear) begin
            state_q <= ST_IDLE;
            dout_q  <= '0;
            hold_q  <= '0;
            phase_q <= 1'b0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            hold_q  <= hold_d;
            phase_q <= phase_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign dout_valid  = valid_q;
    assign dout        = dout_q;
    assign dout_phase  = phase_q;
    assign overflow    = ovf_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_a3_stream_serializer.sv
// Self-checking bench for a3_stream_serializer: a pair-queue + output-slot reference model
// predicts every cycle, and an expected-sample queue checks stream order.
module tb_a3_stream_serializer;

    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic          clk_312_5 = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic          din_valid = 1'b0;
    logic [31:0]   a3_0 = '0;
    logic [31:0]   a3_1 = '0;
    logic          dout_ready = 1'b0;
    logic          dout_valid;
    logic [31:0]   dout;
    logic          dout_phase;
    logic [AW:0]   fifo_level;
    logic          overflow;
    logic [1:0]    dbg_state_o;

    int n_checks = 0;
    int n_pass   = 0;

    // clock / reset
    always #5 clk_312_5 = ~clk_312_5;

    a3_stream_serializer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_312_5   (clk_312_5),
        .rst         (rst),
        .clear       (clear),
        .din_valid   (din_valid),
        .a3_0        (a3_0),
        .a3_1        (a3_1),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .dout        (dout),
        .dout_phase  (dout_phase),
        .fifo_level  (fifo_level),
        .overflow    (overflow),
        .dbg_state_o (dbg_state_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [31:0] fz(input logic [31:0] x);
`ifdef FP32_DENORM_FLUSH_EN
        if (x[30:23] == 8'h00 && x[22:0] != 23'h0) return {x[31], 31'b0};
`endif
        return x;
    endfunction

    // reference model: pairs waiting + one pair in the output slot with rem samples left
    logic [63:0] pq[$];
    logic [31:0] exp_q[$];
    logic [63:0] m_stage = '0;
    int          m_rem = 0;
    logic        m_ovf = 1'b0;

    always @(posedge clk_312_5 or posedge rst) begin
        if (rst || clear) begin
            pq.delete();
            exp_q.delete();
            m_rem = 0;
            m_ovf = 1'b0;
        end else begin
            bit acc, was_full;
            acc = (m_rem > 0) && dout_ready;
            was_full = (pq.size() == DEPTH);
            if (m_rem == 2 && acc) m_rem = 1;
            else if (m_rem == 0 || (m_rem == 1 && acc)) begin
                m_rem = 0;
                if (pq.size() > 0) begin
                    m_stage = pq.pop_front();
                    m_rem = 2;
                end
            end
            if (din_valid) begin
                if (was_full) m_ovf = 1'b1;
                else begin
                    pq.push_back({a3_1, a3_0});
                    exp_q.push_back(fz(a3_0));
                    exp_q.push_back(fz(a3_1));
                end
            end
        end
    end

    // per-cycle monitor / scoreboard
    int   accepts = 0;
    int   lvl_max = 0;
    int   stalls  = 0;
    bit   prev_stall = 0;
    logic [33:0] prev_out = '0;

    always @(negedge clk_312_5) begin
        check("valid", dout_valid, m_rem > 0);
        if (m_rem > 0) begin
            check("dout", dout, (m_rem == 2) ? fz(m_stage[31:0]) : fz(m_stage[63:32]));
            check("phase", dout_phase, m_rem == 1);
        end
        check("level", fifo_level, pq.size());
        check("overflow", overflow, m_ovf);
        if (rst) prev_stall = 0;
        if (prev_stall) check("stable", {dout_valid, dout_phase, dout}, prev_out);
        if (fifo_level > lvl_max) lvl_max = fifo_level;
        if (dout_valid && dout_ready && !clear && !rst) begin
            accepts++;
            if (exp_q.size() == 0) check("sb_underrun", 1, 0);
            else check("sb_order", dout, exp_q.pop_front());
        end
        prev_stall = dout_valid && !dout_ready && !clear && !rst;
        if (prev_stall) stalls++;
        prev_out = {dout_valid, dout_phase, dout};
    end

    // driver tasks
    task automatic tick();
        @(posedge clk_312_5);
        #1;
    endtask

    task automatic send_pair(input logic [31:0] x0, input logic [31:0] x1);
        din_valid = 1'b1;
        a3_0 = x0;
        a3_1 = x1;
        tick();
        din_valid = 1'b0;
    endtask

    function automatic logic [31:0] rnd_fp();
        logic [31:0] x;
        x = $urandom();
        if ($urandom_range(0, 7) == 0) x[30:23] = 8'h00;
        return x;
    endfunction

    task automatic drain();
        int n;
        dout_ready = 1'b1;
        n = 0;
        while ((m_rem != 0 || pq.size() != 0) && n < 400) begin
            tick();
            n++;
        end
        if (n >= 400) check("drain_timeout", 1, 0);
        tick();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // 10 pairs against a stalled consumer, then 11 accepts: EMIT1 with 3 pairs queued
    task automatic fill_emit1();
        dout_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send_pair(rnd_fp(), rnd_fp());
            repeat (3) tick();
        end
        dout_ready = 1'b1;
        repeat (11) tick();
        dout_ready = 1'b0;
    endtask

    initial begin
        int acc0;
        logic [31:0] first_a0;

        // 1: reset held with din_valid toggling
        for (int i = 0; i < 6; i++) begin
            din_valid = i[0];
            a3_0 = $urandom();
            a3_1 = $urandom();
            tick();
            check("rst_valid", dout_valid, 0);
            check("rst_level", fifo_level, 0);
            check("rst_ovf", overflow, 0);
        end
        check("rst_dout", dout, 0);
        check("rst_phase", dout_phase, 0);
        din_valid = 1'b0;
        rst = 1'b0;
        tick();

        // 2: single pair latency
        dout_ready = 1'b1;
        send_pair(32'h3F800000, 32'h40000000);
        @(negedge clk_312_5);
        check("t2_level_k", fifo_level, 1);
        check("t2_valid_k", dout_valid, 0);
        tick();
        @(negedge clk_312_5);
        check("t2_valid_k1", dout_valid, 1);
        check("t2_dout0", dout, 32'h3F800000);
        check("t2_phase0", dout_phase, 0);
        tick();
        @(negedge clk_312_5);
        check("t2_dout1", dout, 32'h40000000);
        check("t2_phase1", dout_phase, 1);
        tick();
        @(negedge clk_312_5);
        check("t2_idle", dout_valid, 0);
        tick();

        // 3: nominal rate, 100 pairs
        lvl_max = 0;
        acc0 = accepts;
        for (int i = 0; i < 100; i++) begin
            send_pair(rnd_fp(), rnd_fp());
            repeat (3) tick();
        end
        drain();
        check("t3_samples", accepts - acc0, 200);
        check("t3_lvl_max", lvl_max, 1);
        check("t3_ovf", overflow, 0);

        // 4: stalled consumer, 10 pairs, last dropped
        dout_ready = 1'b0;
        first_a0 = 32'h0;
        for (int i = 0; i < 10; i++) begin
            logic [31:0] x0;
            x0 = rnd_fp();
            if (i == 0) first_a0 = x0;
            send_pair(x0, rnd_fp());
            repeat (3) tick();
        end
        @(negedge clk_312_5);
        check("t4_level_full", fifo_level, DEPTH);
        check("t4_ovf", overflow, 1);
        check("t4_head", dout, fz(first_a0));
        acc0 = accepts;
        drain();
        check("t4_samples", accepts - acc0, 18);
        check("t4_idle", dout_valid, 0);
        check("t4_ovf_sticky", overflow, 1);
        pulse_clear();

        // 5: random backpressure (ready low 30% of cycles)
        for (int i = 0; i < 60; i++) begin
            int gap;
            din_valid = 1'b1;
            a3_0 = rnd_fp();
            a3_1 = rnd_fp();
            dout_ready = ($urandom_range(0, 99) >= 30);
            tick();
            din_valid = 1'b0;
            gap = $urandom_range(3, 8);
            for (int g = 0; g < gap; g++) begin
                dout_ready = ($urandom_range(0, 99) >= 30);
                tick();
            end
        end
        drain();
        check("t5_stalls_seen", stalls > 0, 1);
        check("t5_sb_empty", exp_q.size(), 0);
        pulse_clear();

        // 6a: clear in EMIT1 with 3 queued; clear beats din_valid
        fill_emit1();
        @(negedge clk_312_5);
        check("t6_state_emit1", dbg_state_o, 2);
        check("t6_level3", fifo_level, 3);
        check("t6_ovf_set", overflow, 1);
        clear = 1'b1;
        din_valid = 1'b1;
        tick();
        clear = 1'b0;
        din_valid = 1'b0;
        @(negedge clk_312_5);
        check("t6_clr_valid", dout_valid, 0);
        check("t6_clr_level", fifo_level, 0);
        check("t6_clr_ovf", overflow, 0);
        check("t6_clr_state", dbg_state_o, 0);
        tick();
        dout_ready = 1'b1;
        send_pair(32'h80000001, 32'h3F800000);
        tick();
        @(negedge clk_312_5);
`ifdef FP32_DENORM_FLUSH_EN
        check("t6_denorm_clr", dout, 32'h80000000);
`else
        check("t6_denorm_clr", dout, 32'h80000001);
`endif
        drain();

        // 6b: async reset in EMIT1 with 3 queued
        fill_emit1();
        @(negedge clk_312_5);
        check("t6_rst_pre_level", fifo_level, 3);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_valid", dout_valid, 0);
        check("t6_rst_level", fifo_level, 0);
        check("t6_rst_ovf", overflow, 0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        dout_ready = 1'b1;
        send_pair(32'h00400000, 32'hC0000000);
        tick();
        @(negedge clk_312_5);
`ifdef FP32_DENORM_FLUSH_EN
        check("t6_denorm_rst", dout, 32'h00000000);
`else
        check("t6_denorm_rst", dout, 32'h00400000);
`endif
        tick();
        @(negedge clk_312_5);
        check("t6_rst_a1", dout, 32'hC0000000);
        drain();
        check("final_sb_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
